uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_pkg.sv | 21 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 24 ++
 rtl/uart_tx_scheduler.sv | 90 +++++++++
 tb/tb_uart_tx_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, default
// sizing and the byte-lane helper used to pick a requester's byte.
package uart_tx_scheduler_pkg;

  localparam int NUM_REQ_DEFAULT      = 4;
  localparam int BUSY_TIMEOUT_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Requester i owns bits [8i+7:8i] of the packed request data bus.
  function automatic logic [7:0] byte_lane(input logic [8*NUM_REQ_DEFAULT-1:0] data,
                                           input logic [1:0] idx);
    return data[8*idx +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational 4-way round-robin priority encoder: the search starts one
// past the last grant and wraps, so the most recent winner ranks last.
module rr_pick
  import uart_tx_scheduler_pkg::*;
(
  input  logic [NUM_REQ_DEFAULT-1:0] req,
  input  logic [1:0]                 last_grant,
  output logic                       valid,
  output logic [1:0]                 winner
);

  always_comb begin
    valid  = 1'b0;
    winner = 2'd0;
    // 2-bit index arithmetic wraps 3 -> 0 for free.
    for (int k = 1; k <= NUM_REQ_DEFAULT; k++) begin
      if (!valid && req[last_grant + 2'(k)]) begin
        valid  = 1'b1;
        winner = last_grant + 2'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one async_transmitter between four byte requesters. Handshake: a
// requester holds req[i] and its byte until a one-cycle ack[i]; TxD_start
// fires with that ack, and a new byte is only offered while TxD_busy is low.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic                   CLK_IN,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   TxD_start,
  output logic [7:0]             TxD_data,
  input  logic                   TxD_busy,
  output logic [1:0]             grant_id,
  output logic                   active,
  output logic                   tx_err,
  output logic [1:0]             state_dbg
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [1:0]      last_grant;
  logic [CW-1:0]   to_cnt;
  logic            to_expired;
  logic            pick_valid;
  logic [1:0]      pick_id;

  rr_pick u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  // to_cnt holds the number of cycles since the START cycle.
  assign to_expired = (to_cnt == CW'(BUSY_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (pick_valid && !TxD_busy) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (TxD_busy)        state_nxt = S_WAIT_DONE;
        else if (to_expired) state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!TxD_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign TxD_start = (state == S_START);
  assign ack       = TxD_start ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign active    = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state      <= S_IDLE;
      TxD_data   <= 8'd0;
      grant_id   <= 2'd0;
      last_grant <= 2'd3;
      to_cnt     <= '0;
      tx_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      // Byte and owner are captured only on acceptance and held until the next one.
      if (state == S_IDLE && state_nxt == S_START) begin
        TxD_data <= byte_lane(req_data, pick_id);
        grant_id <= pick_id;
      end
      if (state == S_START) begin
        last_grant <= grant_id;
        to_cnt     <= CW'(1);
      end else if (state == S_WAIT_BUSY && !TxD_busy && !to_expired) begin
        to_cnt <= to_cnt + CW'(1);
      end else if (state != S_WAIT_BUSY) begin
        to_cnt <= '0;
      end
      if (state == S_WAIT_BUSY && !TxD_busy && to_expired)
        tx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: random requesters, a model
// transmitter with random busy delays, and a cycle-timed reference model.
module tb_uart_tx_scheduler;

  localparam int T     = 8;
  localparam int NCYC  = 6000;
  localparam int NEVER = 32'h3fffffff;

  logic        CLK_IN = 1'b0;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        TxD_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_err;
  logic [1:0]  state_dbg;

  uart_tx_scheduler #(.NUM_REQ(4), .BUSY_TIMEOUT(T)) dut (
    .CLK_IN    (CLK_IN),
    .RST       (RST),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .TxD_busy  (TxD_busy),
    .grant_id  (grant_id),
    .active    (active),
    .tx_err    (tx_err),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  always #5 CLK_IN = ~CLK_IN;
  int cyc = 0;
  always @(posedge CLK_IN) cyc <= cyc + 1;

  // Scoreboard: expected starts {cycle, id, data} and per-cycle status {cycle, rst, active, err}
  logic [41:0] exp_q[$];
  logic [34:0] st_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, expv);
    end
  endtask

  // Round-robin rule: search from last+1, wrapping, first requester set wins.
  function automatic logic [1:0] rr_model(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(last) + k) % 4;
      if (r[idx]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  // Monitor
  logic [41:0] mon_e;
  logic [34:0] mon_s;
  logic [1:0]  held_id   = 2'd0;
  logic [7:0]  held_data = 8'd0;

  always @(negedge CLK_IN) begin
    if (st_q.size() > 0 && int'(st_q[0][34:3]) == cyc) begin
      mon_s = st_q.pop_front();
      if (mon_s[2]) begin
        held_id   = 2'd0;
        held_data = 8'd0;
      end
      chk("active", 32'(active), 32'(mon_s[1]));
      chk("state_not_idle", 32'(state_dbg != 2'd0), 32'(mon_s[1]));
      chk("tx_err", 32'(tx_err), 32'(mon_s[0]));
    end
    if (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
      chk("missing_start", 32'(0), 32'(1));
      void'(exp_q.pop_front());
    end
    if (TxD_start) begin
      if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
        mon_e = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(mon_e[9:8]));
        chk("TxD_data", 32'(TxD_data), 32'(mon_e[7:0]));
        chk("ack_onehot", 32'(ack), 32'(4'b0001 << mon_e[9:8]));
        held_id   = mon_e[9:8];
        held_data = mon_e[7:0];
      end else begin
        chk("unexpected_start", 32'(1), 32'(0));
      end
    end else begin
      if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
        chk("missing_start", 32'(0), 32'(1));
        void'(exp_q.pop_front());
      end
      chk("ack_idle", 32'(ack), 32'(0));
      chk("grant_hold", 32'(grant_id), 32'(held_id));
      chk("data_hold", 32'(TxD_data), 32'(held_data));
    end
  end

  // Driver, model transmitter and reference model
  logic [3:0] pending;
  logic [7:0] pdata [4];
  logic [1:0] lg, id;
  logic       plan_valid, busy_now, rst_now;
  int         ready, err_at, plan_s, plan_d, plan_l, rst_left, load, c, j;

  initial begin
    RST = 1'b1; req = '0; req_data = '0; TxD_busy = 1'b0;
    pending = 4'hf;
    for (int i = 0; i < 4; i++) pdata[i] = 8'h30 + 8'(i);
    lg = 2'd3; ready = 0; err_at = NEVER; plan_valid = 1'b0;
    plan_s = 0; plan_d = 0; plan_l = 0; rst_left = 3; load = 100;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge CLK_IN);
      c = cyc;
      if (c >= 400 && c % 500 == 0) load = $urandom_range(10, 100);

      // Model transmitter: busy for plan_l cycles starting plan_d after the start
      j = c - plan_s;
      busy_now = plan_valid && (j >= plan_d) && (j < plan_d + plan_l);

      // Occasional reset while the transmitter is still busy with a byte
      rst_now = 1'b0;
      if (rst_left > 0) begin
        rst_now = 1'b1;
        rst_left--;
      end else if (plan_valid && c > 400 && plan_d < T && j > plan_d &&
                   j + 2 < plan_d + plan_l && $urandom_range(0, 29) == 0) begin
        rst_now  = 1'b1;
        rst_left = $urandom_range(0, 1);
      end

      // Requesters: hold until ack, maybe re-raise, occasionally withdraw
      for (int i = 0; i < 4; i++) begin
        if (pending[i] && ack[i]) begin
          pending[i] = 1'b0;
          if ($urandom_range(0, 99) < load) begin
            pending[i] = 1'b1;
            pdata[i]   = 8'($urandom);
          end
        end else if (pending[i]) begin
          if (load < 100 && $urandom_range(0, 63) == 0) pending[i] = 1'b0;
        end else if ($urandom_range(0, 99) < load / 2) begin
          pending[i] = 1'b1;
          pdata[i]   = 8'($urandom);
        end
      end

      RST      = rst_now;
      TxD_busy = busy_now;
      req      = pending;
      for (int i = 0; i < 4; i++)
        req_data[8*i +: 8] = pending[i] ? pdata[i] : 8'($urandom);

      // Reference model: expectations for the next cycle
      if (rst_now) begin
        lg     = 2'd3;
        err_at = NEVER;
        ready  = c + 1;
        st_q.push_back({32'(c + 1), 1'b1, 1'b0, 1'b0});
      end else begin
        if (c >= ready && pending != 4'd0 && !busy_now) begin
          id = rr_model(pending, lg);
          lg = id;
          exp_q.push_back({32'(c + 1), id, pdata[id]});
          plan_valid = 1'b1;
          plan_s     = c + 1;
          if ($urandom_range(0, 7) == 0) begin
            plan_d = T + $urandom_range(0, 6);
            plan_l = $urandom_range(0, 6);
            ready  = plan_s + T;
            if (err_at == NEVER) err_at = plan_s + T;
          end else begin
            plan_d = $urandom_range(1, T - 1);
            plan_l = $urandom_range(1, 12);
            ready  = plan_s + plan_d + plan_l + 1;
          end
        end
        st_q.push_back({32'(c + 1), 1'b0, (c + 1 < ready), (c + 1 >= err_at)});
      end
    end

    @(negedge CLK_IN);
    @(negedge CLK_IN);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
